agc_gain_apply: RTL

AGC_GAIN_APPLY -- requirements
Module: agc_gain_apply

---
 rtl/agc_pkg.sv | 22 ++
 rtl/agc_sat_round.sv | 48 ++++
 rtl/agc_gain_apply.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC gain-apply block: default widths, the unity-gain word and the FSM state type.
package agc_pkg;

    localparam int AGC_DWIDTH_DEF  = 16;
    localparam int AGC_GWIDTH_DEF  = 48;
    localparam int AGC_GSHIFT_DEF  = 12;
    localparam int AGC_GBITS_DEF   = 18;
    localparam int AGC_GFRAC_DEF   = 14;
    localparam int AGC_AWIDTH_DEF  = 30;
    localparam int AGC_BLANK_N_DEF = 4;

    // 1.0 in the default unsigned Q(GBITS-GFRAC).GFRAC gain format
    localparam logic [AGC_GBITS_DEF-1:0] AGC_UNITY_GAIN = 18'h04000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BLANK  = 2'd2,
        FREEZE = 2'd3
    } agc_state_t;

endpackage

// File: rtl/agc_sat_round.sv
// Round-half-up, arithmetic right shift by GFRAC and saturation of the gained product to DWIDTH.
module agc_sat_round #(
    parameter int PWIDTH = 35,
    parameter int DWIDTH = 16,
    parameter int GFRAC  = 14
) (
    input  logic signed [PWIDTH-1:0] i_prod,
    input  logic                     i_valid,
    output logic signed [DWIDTH-1:0] o_data,
    output logic                     o_sat
);

    localparam int SWIDTH  = PWIDTH + 1;
    localparam int SHWIDTH = SWIDTH - GFRAC;

    localparam logic signed [SWIDTH-1:0] RND =
        {{(SWIDTH-GFRAC){1'b0}}, 1'b1, {(GFRAC-1){1'b0}}};
    localparam logic signed [DWIDTH-1:0] DMAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] DMIN = {1'b1, {(DWIDTH-1){1'b0}}};

    logic signed [SWIDTH-1:0]  w_sum;
    logic signed [SHWIDTH-1:0] w_shift;
    logic [SHWIDTH-DWIDTH:0]   w_hi;
    logic                      w_pos_ovf;
    logic                      w_neg_ovf;
    logic                      w_unused_frac;

    // One guard bit keeps the rounding add from wrapping at the product extremes
    assign w_sum   = {i_prod[PWIDTH-1], i_prod} + RND;
    assign w_shift = w_sum[SWIDTH-1:GFRAC];
    assign w_unused_frac = ^w_sum[GFRAC-1:0];

    assign w_hi      = w_shift[SHWIDTH-1:DWIDTH-1];
    assign w_pos_ovf = ~w_shift[SHWIDTH-1] & (|w_hi);
    assign w_neg_ovf =  w_shift[SHWIDTH-1] & ~(&w_hi);

    always_comb begin
        o_data = w_shift[DWIDTH-1:0];
        if (w_pos_ovf) begin
            o_data = DMAX;
        end else if (w_neg_ovf) begin
            o_data = DMIN;
        end
    end

    assign o_sat = i_valid & (w_pos_ovf | w_neg_ovf);

endmodule

// File: rtl/agc_gain_apply.sv
// AGC gain application: 3-stage gained/saturated sample path plus a level stage gated by a blanking FSM.
// Optional macro AGC_SAT_CNT_EN enables the 16-bit saturation event counter (sat_cnt reads 0 otherwise).
module agc_gain_apply
    import agc_pkg::*;
#(
    parameter int DWIDTH  = AGC_DWIDTH_DEF,
    parameter int GWIDTH  = AGC_GWIDTH_DEF,
    parameter int GSHIFT  = AGC_GSHIFT_DEF,
    parameter int GBITS   = AGC_GBITS_DEF,
    parameter int GFRAC   = AGC_GFRAC_DEF,
    parameter int AWIDTH  = AGC_AWIDTH_DEF,
    parameter int BLANK_N = AGC_BLANK_N_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DWIDTH-1:0] din,
    input  logic                     din_valid,
    input  logic signed [GWIDTH-1:0] gain_in,
    input  logic                     gain_valid,
    input  logic                     freeze,
    output logic signed [DWIDTH-1:0] dout,
    output logic                     dout_valid,
    output logic        [AWIDTH-1:0] level_out,
    output logic                     level_valid,
    output logic                     sat_flag,
    output logic        [15:0]       sat_cnt
);

    localparam int PWIDTH = DWIDTH + GBITS + 1;
    localparam int CWIDTH = (BLANK_N < 2) ? 1 : $clog2(BLANK_N + 1);
    localparam logic [GBITS-1:0] UNITY = {{(GBITS-GFRAC-1){1'b0}}, 1'b1, {GFRAC{1'b0}}};
    localparam logic [GBITS-1:0] GMAX  = {GBITS{1'b1}};

    logic        [GBITS-1:0]  r_g;
    logic signed [DWIDTH-1:0] r_din;
    logic                     r_s1_valid;
    logic signed [PWIDTH-1:0] r_prod;
    logic                     r_s2_valid;
    logic signed [DWIDTH-1:0] r_dout;
    logic                     r_dout_valid;
    logic                     r_sat_flag;
    logic        [AWIDTH-1:0] r_level;
    logic                     r_level_valid;
    agc_state_t               r_state;
    logic        [CWIDTH-1:0] r_blank_cnt;

    logic                     w_gain_accept;
    logic        [GBITS-1:0]  w_gain_next;
    logic signed [PWIDTH-1:0] w_din_ext;
    logic signed [PWIDTH-1:0] w_gain_ext;
    logic signed [PWIDTH-1:0] w_prod;
    logic signed [DWIDTH-1:0] w_round;
    logic                     w_sat;
    logic signed [DWIDTH:0]   w_dout_ext;
    logic        [DWIDTH:0]   w_abs;
    logic        [AWIDTH-1:0] w_level;
    logic                     w_unused_gain_lsbs;

    assign w_gain_accept      = gain_valid & ~freeze;
    assign w_unused_gain_lsbs = ^gain_in[GSHIFT-1:0];

    // Negative loop words clamp to zero gain, anything above the field clamps to full scale
    always_comb begin
        w_gain_next = gain_in[GSHIFT+GBITS-1:GSHIFT];
        if (gain_in[GWIDTH-1]) begin
            w_gain_next = '0;
        end else if (|gain_in[GWIDTH-2:GSHIFT+GBITS]) begin
            w_gain_next = GMAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g <= UNITY;
        end else if (w_gain_accept) begin
            r_g <= w_gain_next;
        end
    end

    // Gain is zero-extended by one bit so the multiply stays signed
    assign w_din_ext  = {{(GBITS+1){r_din[DWIDTH-1]}}, r_din};
    assign w_gain_ext = {{DWIDTH{1'b0}}, 1'b0, r_g};
    assign w_prod     = w_din_ext * w_gain_ext;

    agc_sat_round #(
        .PWIDTH (PWIDTH),
        .DWIDTH (DWIDTH),
        .GFRAC  (GFRAC)
    ) u_sat_round (
        .i_prod  (r_prod),
        .i_valid (r_s2_valid),
        .o_data  (w_round),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din        <= '0;
            r_s1_valid   <= 1'b0;
            r_prod       <= '0;
            r_s2_valid   <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sat_flag   <= 1'b0;
        end else begin
            r_s1_valid   <= din_valid;
            r_s2_valid   <= r_s1_valid;
            r_dout_valid <= r_s2_valid;
            if (din_valid) begin
                r_din <= din;
            end
            if (r_s1_valid) begin
                r_prod <= w_prod;
            end
            if (r_s2_valid) begin
                r_dout <= w_round;
            end
            if (w_sat) begin
                r_sat_flag <= 1'b1;
            end
        end
    end

`ifdef AGC_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (w_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    assign sat_cnt = 16'd0;
`endif

    // -2^(DWIDTH-1) needs the extra bit to become +2^(DWIDTH-1)
    assign w_dout_ext = {r_dout[DWIDTH-1], r_dout};
    assign w_abs      = r_dout[DWIDTH-1] ? (-w_dout_ext) : w_dout_ext;
    assign w_level    = {{(AWIDTH-DWIDTH-1){1'b0}}, w_abs};

    // r_dout_valid marks the sample entering the level stage on this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_blank_cnt   <= '0;
            r_level       <= '0;
            r_level_valid <= 1'b0;
        end else begin
            r_level_valid <= 1'b0;
            if (r_dout_valid && (r_state != BLANK)) begin
                r_level       <= w_level;
                r_level_valid <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (din_valid) begin
                        r_state <= freeze ? FREEZE : RUN;
                    end
                end
                RUN: begin
                    if (freeze) begin
                        r_state <= FREEZE;
                    end else if (w_gain_accept) begin
                        r_state     <= BLANK;
                        r_blank_cnt <= CWIDTH'(BLANK_N);
                    end
                end
                BLANK: begin
                    if (freeze) begin
                        r_state <= FREEZE;
                    end else if (w_gain_accept) begin
                        r_blank_cnt <= CWIDTH'(BLANK_N);
                    end else if (r_dout_valid) begin
                        r_blank_cnt <= r_blank_cnt - CWIDTH'(1);
                        if (r_blank_cnt <= CWIDTH'(1)) begin
                            r_state <= RUN;
                        end
                    end
                end
                FREEZE: begin
                    if (!freeze) begin
                        if (w_gain_accept) begin
                            r_state     <= BLANK;
                            r_blank_cnt <= CWIDTH'(BLANK_N);
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign level_out   = r_level;
    assign level_valid = r_level_valid;
    assign sat_flag    = r_sat_flag;

endmodule
